// File: rtl/led_pattern_scheduler.sv
// 16-LED pattern sequencer: programmable step timebase, four patterns (BOUNCE, SHIFT, FILL, BLINK),
// and mode changes deferred to the next step boundary.
module led_pattern_scheduler #(
  parameter int unsigned TICK_DIV = 25_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mode_sel,
  input  logic        mode_load,
  input  logic        pause,
  output logic [15:0] LED,
  output logic [1:0]  cur_mode,
  output logic        busy,
  output logic        step_tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    M_BOUNCE = 2'd0,
    M_SHIFT  = 2'd1,
    M_FILL   = 2'd2,
    M_BLINK  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    B_UP,
    B_DWELL_HI,
    B_DOWN,
    B_DWELL_LO
  } bdir_e;

  logic [CW-1:0] cnt_q, cnt_d;
  mode_e         mode_q, mode_d;
  logic [1:0]    pend_q, pend_d;
  logic          busy_q, busy_d;
  logic          tick_q, tick_d;
  logic [15:0]   led_q, led_d;
  logic [3:0]    pos_q, pos_d;
  bdir_e         bdir_q, bdir_d;
  logic [4:0]    lvl_q, lvl_d;
  logic          fup_q, fup_d;
  logic [16:0]   fill_mask;
  logic          strobe;

  assign strobe = !pause && (cnt_q == TERM);

  always_comb begin
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    pend_d    = pend_q;
    busy_d    = busy_q;
    tick_d    = strobe;
    led_d     = led_q;
    pos_d     = pos_q;
    bdir_d    = bdir_q;
    lvl_d     = lvl_q;
    fup_d     = fup_q;
    fill_mask = '0;

    if (!pause) begin
      cnt_d = strobe ? '0 : cnt_q + 1'b1;
    end

    if (strobe) begin
      if (busy_q) begin
        // A switching step only loads the entry pattern; it never advances it.
        mode_d = mode_e'(pend_q);
        pos_d  = 4'd8;
        bdir_d = B_UP;
        lvl_d  = '0;
        fup_d  = 1'b1;
        led_d  = (mode_e'(pend_q) == M_SHIFT) ? 16'h0001 : '0;
      end else begin
        unique case (mode_q)
          M_BOUNCE: begin
            led_d[pos_q] = ~led_q[pos_q];
            unique case (bdir_q)
              B_UP: begin
                if (pos_q == 4'd15) bdir_d = B_DWELL_HI;
                else                pos_d  = pos_q + 4'd1;
              end
              B_DWELL_HI: bdir_d = B_DOWN;
              B_DOWN: begin
                if (pos_q == 4'd0) bdir_d = B_DWELL_LO;
                else               pos_d  = pos_q - 4'd1;
              end
              B_DWELL_LO: bdir_d = B_UP;
            endcase
          end
          M_SHIFT: led_d = {led_q[14:0], led_q[15]};
          M_FILL: begin
            if (fup_q) begin
              if (lvl_q == 5'd16) begin
                fup_d = 1'b0;
                lvl_d = 5'd15;
              end else begin
                lvl_d = lvl_q + 5'd1;
              end
            end else begin
              if (lvl_q == 5'd0) begin
                fup_d = 1'b1;
                lvl_d = 5'd1;
              end else begin
                lvl_d = lvl_q - 5'd1;
              end
            end
            fill_mask = (17'd1 << lvl_d) - 17'd1;
            led_d     = fill_mask[15:0];
          end
          M_BLINK: led_d = ~led_q;
        endcase
      end
      busy_d = 1'b0;
    end

    // A load coinciding with a strobe survives it and waits for the next one.
    if (mode_load) begin
      pend_d = mode_sel;
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      mode_q <= M_BOUNCE;
      pend_q <= '0;
      busy_q <= 1'b0;
      tick_q <= 1'b0;
      led_q  <= '0;
      pos_q  <= 4'd8;
      bdir_q <= B_UP;
      lvl_q  <= '0;
      fup_q  <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      pend_q <= pend_d;
      busy_q <= busy_d;
      tick_q <= tick_d;
      led_q  <= led_d;
      pos_q  <= pos_d;
      bdir_q <= bdir_d;
      lvl_q  <= lvl_d;
      fup_q  <= fup_d;
    end
  end

  assign LED       = led_q;
  assign cur_mode  = mode_q;
  assign busy      = busy_q;
  assign step_tick = tick_q;

endmodule

// File: tb/tb_led_pattern_scheduler.sv
// Bench for led_pattern_scheduler: directed scenarios plus random mode/pause traffic,
// checked every cycle against a step-indexed reference model.
module tb_led_pattern_scheduler;

  localparam int TD = 4;

  logic        clk;
  logic        reset;
  logic [1:0]  mode_sel;
  logic        mode_load;
  logic        pause;
  logic [15:0] LED;
  logic [1:0]  cur_mode;
  logic        busy;
  logic        step_tick;

  led_pattern_scheduler #(.TICK_DIV(TD)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode_sel  (mode_sel),
    .mode_load (mode_load),
    .pause     (pause),
    .LED       (LED),
    .cur_mode  (cur_mode),
    .busy      (busy),
    .step_tick (step_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: pattern value as a function of steps since entry.
  int          bseq[34];
  int          m_cnt;
  int          m_n;
  logic [1:0]  m_mode;
  logic [1:0]  m_pend;
  logic        m_busy;
  logic        m_tick;
  logic [15:0] m_led;
  logic [15:0] m_bled;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] led_of(input logic [1:0] mode, input int n, input logic [15:0] bled);
    logic [15:0] one;
    int          lvl;
    int          ph;
    one = 16'h0001;
    case (mode)
      2'd0: return bled;
      2'd1: return one << (n % 16);
      2'd2: begin
        ph  = n % 32;
        lvl = (ph <= 16) ? ph : 32 - ph;
        if (lvl == 16) return 16'hFFFF;
        return (one << lvl) - 16'd1;
      end
      default: return (n % 2 == 1) ? 16'hFFFF : 16'h0000;
    endcase
  endfunction

  task automatic model_reset();
    m_cnt  = 0;
    m_n    = 0;
    m_mode = 2'd0;
    m_pend = 2'd0;
    m_busy = 1'b0;
    m_tick = 1'b0;
    m_led  = 16'h0000;
    m_bled = 16'h0000;
  endtask

  task automatic model_step();
    logic stb;
    int   idx;
    stb = !pause && (m_cnt == TD - 1);
    if (!pause) m_cnt = stb ? 0 : m_cnt + 1;
    m_tick = stb;
    if (stb) begin
      if (m_busy) begin
        m_mode = m_pend;
        m_n    = 0;
        m_bled = 16'h0000;
      end else begin
        m_n++;
        if (m_mode == 2'd0) begin
          idx = bseq[(8 + m_n - 1) % 34];
          m_bled[idx] = ~m_bled[idx];
        end
      end
      m_busy = 1'b0;
    end
    if (mode_load) begin
      m_busy = 1'b1;
      m_pend = mode_sel;
    end
    m_led = led_of(m_mode, m_n, m_bled);
  endtask

  task automatic cyc(input logic ld, input logic [1:0] sel, input logic pz);
    mode_load = ld;
    mode_sel  = sel;
    pause     = pz;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("led", LED, m_led);
    check("cur_mode", cur_mode, m_mode);
    check("busy", busy, m_busy);
    check("step_tick", step_tick, m_tick);
    mode_load = 1'b0;
  endtask

  task automatic run_steps(input int n);
    int seen;
    int guard;
    seen  = 0;
    guard = 0;
    while (seen < n && guard < n * TD * 3 + 8) begin
      cyc(1'b0, 2'd0, 1'b0);
      if (step_tick) seen++;
      guard++;
    end
    check("step_budget", seen, n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "time limit exceeded");
  end

  initial begin
    int   k;
    logic pz;

    for (int i = 0; i < 16; i++) begin
      bseq[i]      = i;
      bseq[17 + i] = 15 - i;
    end
    bseq[16] = 15;
    bseq[33] = 0;

    reset     = 1'b1;
    mode_load = 1'b0;
    mode_sel  = 2'd0;
    pause     = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_led", LED, 16'h0000);
    check("rst_mode", cur_mode, 2'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_tick", step_tick, 1'b0);
    reset = 1'b0;

    // Bounce from reset
    run_steps(8);  check("t1_s8", LED, 16'hFF00);
    run_steps(1);  check("t1_s9", LED, 16'h7F00);
    run_steps(1);  check("t1_s10", LED, 16'hFF00);
    run_steps(1);  check("t1_s11", LED, 16'hBF00);

    // Switch to SHIFT between steps
    cyc(1'b0, 2'd0, 1'b0);
    cyc(1'b1, 2'd1, 1'b0);
    check("t2_busy", busy, 1'b1);
    run_steps(1);
    check("t2_entry", LED, 16'h0001);
    check("t2_mode", cur_mode, 2'd1);
    check("t2_busy_clr", busy, 1'b0);
    run_steps(1);  check("t2_s1", LED, 16'h0002);
    run_steps(15); check("t2_s16", LED, 16'h0001);

    // FILL triangle
    cyc(1'b1, 2'd2, 1'b0);
    run_steps(1);  check("t3_entry", LED, 16'h0000);
    run_steps(1);  check("t3_s1", LED, 16'h0001);
    run_steps(1);  check("t3_s2", LED, 16'h0003);
    run_steps(14); check("t3_s16", LED, 16'hFFFF);
    run_steps(1);  check("t3_s17", LED, 16'h7FFF);
    run_steps(15); check("t3_s32", LED, 16'h0000);
    run_steps(1);  check("t3_s33", LED, 16'h0001);

    // Pause with counter at 2
    cyc(1'b0, 2'd0, 1'b0);
    cyc(1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 2'd0, 1'b1);
      check("t4_hold_led", LED, 16'h0001);
    end
    k = 0;
    do begin
      cyc(1'b0, 2'd0, 1'b0);
      k++;
    end while (!step_tick && k < 20);
    check("t4_resume_clks", k, 2);
    check("t4_resume_led", LED, 16'h0003);

    // Last request wins; load on the strobe waits one more step
    cyc(1'b1, 2'd3, 1'b0);
    cyc(1'b1, 2'd1, 1'b0);
    run_steps(1);
    check("t5_mode", cur_mode, 2'd1);
    check("t5_led", LED, 16'h0001);
    repeat (3) cyc(1'b0, 2'd0, 1'b0);
    cyc(1'b1, 2'd2, 1'b0);
    check("t5_coinc_tick", step_tick, 1'b1);
    check("t5_coinc_busy", busy, 1'b1);
    check("t5_coinc_mode", cur_mode, 2'd1);
    run_steps(1);
    check("t5_late_mode", cur_mode, 2'd2);
    check("t5_late_led", LED, 16'h0000);

    // Random traffic
    pz = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) pz = ~pz;
      cyc($urandom_range(0, 15) == 0, 2'($urandom_range(0, 3)), pz);
    end

    // Async reset mid-FILL with a pending mode
    cyc(1'b1, 2'd2, 1'b0);
    run_steps(1);
    run_steps(3);
    check("t6_fill", LED, 16'h0007);
    cyc(1'b1, 2'd3, 1'b0);
    check("t6_busy", busy, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("t6_async_led", LED, 16'h0000);
    check("t6_async_mode", cur_mode, 2'd0);
    check("t6_async_busy", busy, 1'b0);
    check("t6_async_tick", step_tick, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    run_steps(1);
    check("t6_restart_led", LED, 16'h0100);
    check("t6_restart_mode", cur_mode, 2'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
